tdm_deframer8: RTL and testbench
================================

Name: tdm_deframer8

Overview:
- Receive-side front end of the audio mixer: deserialises a bit-serial TDM stream of 8 slots × 16-bit two's-complement samples into 8 parallel channel words.
- Feeds the 8-input summing stage (ch1..ch8 wire directly to its 8 inputs).
- Tracks frame alignment via a frame-sync strobe, flags sync errors, and publishes a complete frame atomically with a one-cycle valid pulse.

Parameters:
- W, 16, sample width in bits per slot (slot count fixed at 8).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- bit_en  in  1  bit strobe; sdata/fsync sampled only on cycles with bit_en=1.
- sdata  in  1  serial data, MSB first, slot 0 first.
- fsync  in  1  frame sync; high coincident with the MSB of slot 0.
- ch1..ch8  out  W each  channel samples of last complete frame (ch1 = slot 0 … ch8 = slot 7).
- frame_valid  out  1  one-cycle pulse: ch1..ch8 just updated.
- sync_err  out  1  one-cycle pulse: framing violation detected.
- locked  out  1  high while in RUN.

Behaviour:
- Reset (async assert, sync-released): state=HUNT, bit_cnt=0, slot_cnt=0, shift reg and shadow regs=0, ch1..ch8=0, frame_valid=0, sync_err=0, locked=0.
- Cycles with bit_en=0: no state change; frame_valid/sync_err return to 0. Gaps of any length between strobes are legal.
- HUNT: on bit_en & fsync → capture sdata as MSB of slot 0, bit_cnt=1, slot_cnt=0, go RUN. bit_en & !fsync → ignored.
- RUN, per bit_en:
  - Shift sdata into the shift reg (MSB first); bit_cnt increments, wrapping at W.
  - On the W-th bit of a slot: the complete word goes to shadow[slot_cnt]; slot_cnt increments.
  - On the W-th bit of slot 7: ch1..ch8 load from shadow (slot 7 word taken directly from the shift path); frame_valid=1 for exactly one cycle; bit_cnt=0, slot_cnt=0; remain RUN.
- Expected fsync position is bit 0 of slot 0 only.
  - fsync=1 at any other bit position: sync_err pulse; partial frame discarded (ch outputs unchanged, no frame_valid); this bit taken as MSB of a new slot 0 (bit_cnt=1, slot_cnt=0); stay RUN.
  - fsync=0 at the expected position: sync_err pulse; bit ignored; go HUNT (locked=0).
- Frame completion and the next fsync can never share a bit_en (different strobes); back-to-back frames with no idle strobes are the normal case.
- Latency: ch1..ch8 and frame_valid update on the clock edge that samples the final LSB strobe; visible the following cycle.
- Outputs hold the last complete frame indefinitely. Outputs are never partially updated.
- frame_valid and sync_err are never high in the same cycle.
- Reset mid-frame: immediate return to reset values; the partial frame is lost.
- No arithmetic on data; samples pass bit-exact, sign preserved.

Test Plan:
- Reset, then one frame with bit_en every cycle, slots = 0x0001, 0x8000, 0x7FFF, 0xFFFF, 0x1234, 0xABCD, 0x0000, 0x5A5A, fsync on the first bit.
  → Exactly 128 cycles after the first bit, frame_valid pulses once.
  → ch1..ch8 equal those values in order; locked=1; sync_err never asserted.
- Two back-to-back frames, the second with all slots = 0xC3C3; bit_en high every 3rd cycle.
  → Two frame_valid pulses 384 cycles apart.
  → Outputs hold frame 1 values until the second pulse, then all read 0xC3C3.
- Early fsync at bit 5 of slot 3, followed by a full clean frame.
  → sync_err pulses once; no frame_valid for the partial frame; outputs keep prior values.
  → frame_valid arrives 128 strobes after the early fsync, with the clean frame's data.
- fsync missing at the start of the second frame.
  → sync_err pulse; locked drops; subsequent bits ignored and no frame_valid until the next fsync.
  → After that fsync and a full frame, correct data with frame_valid.
- Assert rst_n low in the middle of slot 4, then release.
  → Outputs go to 0 asynchronously; locked=0.
  → A new complete frame after release is received correctly.
- Stream with fsync held low throughout.
  → Stays in HUNT; outputs remain 0; no frame_valid or sync_err pulses.

Source files
------------

// File: rtl/tdm_deframer8_if.sv
// Serial TDM input strobes and parallel frame outputs of the 8-slot deframer.
interface tdm_deframer8_if #(
    parameter int W = 16
);
    logic         bit_en;
    logic         sdata;
    logic         fsync;
    logic [W-1:0] ch1;
    logic [W-1:0] ch2;
    logic [W-1:0] ch3;
    logic [W-1:0] ch4;
    logic [W-1:0] ch5;
    logic [W-1:0] ch6;
    logic [W-1:0] ch7;
    logic [W-1:0] ch8;
    logic         frame_valid;
    logic         sync_err;
    logic         locked;

    modport master (
        output bit_en, sdata, fsync,
        input  ch1, ch2, ch3, ch4, ch5, ch6, ch7, ch8, frame_valid, sync_err, locked
    );

    modport slave (
        input  bit_en, sdata, fsync,
        output ch1, ch2, ch3, ch4, ch5, ch6, ch7, ch8, frame_valid, sync_err, locked
    );
endinterface

// File: rtl/tdm_deframer8.sv
// Deserialises an 8-slot x W-bit MSB-first TDM stream, tracks fsync alignment
// and publishes each complete frame atomically with a one-cycle valid pulse.
module tdm_deframer8 #(
    parameter int W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    tdm_deframer8_if.slave   bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {S_HUNT, S_RUN} state_t;

    state_t        r_state;
    logic [CW-1:0] r_bit_cnt;
    logic [2:0]    r_slot_cnt;
    logic [W-1:0]  r_shift;
    logic [W-1:0]  r_shadow [7];
    logic [W-1:0]  r_ch     [8];
    logic          r_frame_valid;
    logic          r_sync_err;
    logic          r_locked;

    logic [W-1:0]  w_word;
    logic          w_frame_start;
    logic          w_last_bit;

    assign w_word        = {r_shift[W-2:0], bus.sdata};
    assign w_frame_start = (r_bit_cnt == '0) && (r_slot_cnt == '0);
    assign w_last_bit    = (r_bit_cnt == CW'(W - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_HUNT;
            r_bit_cnt     <= '0;
            r_slot_cnt    <= '0;
            r_shift       <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_locked      <= 1'b0;
            for (int unsigned i = 0; i < 7; i++) r_shadow[i] <= '0;
            for (int unsigned i = 0; i < 8; i++) r_ch[i] <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (bus.bit_en) begin
                case (r_state)
                    S_HUNT: begin
                        if (bus.fsync) begin
                            r_shift    <= w_word;
                            r_bit_cnt  <= CW'(1);
                            r_slot_cnt <= '0;
                            r_state    <= S_RUN;
                            r_locked   <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (bus.fsync && !w_frame_start) begin
                            // Early fsync restarts slot 0 with this bit as its MSB.
                            r_sync_err <= 1'b1;
                            r_shift    <= w_word;
                            r_bit_cnt  <= CW'(1);
                            r_slot_cnt <= '0;
                        end else if (!bus.fsync && w_frame_start) begin
                            r_sync_err <= 1'b1;
                            r_state    <= S_HUNT;
                            r_locked   <= 1'b0;
                        end else begin
                            r_shift <= w_word;
                            if (w_last_bit) begin
                                r_bit_cnt  <= '0;
                                r_slot_cnt <= r_slot_cnt + 3'd1;
                                if (r_slot_cnt == 3'd7) begin
                                    for (int unsigned i = 0; i < 7; i++) r_ch[i] <= r_shadow[i];
                                    r_ch[7]       <= w_word;
                                    r_frame_valid <= 1'b1;
                                end else begin
                                    r_shadow[r_slot_cnt] <= w_word;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_HUNT;
                endcase
            end
        end
    end

    assign bus.ch1         = r_ch[0];
    assign bus.ch2         = r_ch[1];
    assign bus.ch3         = r_ch[2];
    assign bus.ch4         = r_ch[3];
    assign bus.ch5         = r_ch[4];
    assign bus.ch6         = r_ch[5];
    assign bus.ch7         = r_ch[6];
    assign bus.ch8         = r_ch[7];
    assign bus.frame_valid = r_frame_valid;
    assign bus.sync_err    = r_sync_err;
    assign bus.locked      = r_locked;
endmodule

// File: tb/tb_tdm_deframer8.sv
// Directed bench for tdm_deframer8: clean frames, strobe gaps, early/missing
// fsync, mid-frame reset and a stream that never syncs.
module tb_tdm_deframer8;
    localparam int W = 16;
    typedef logic [W-1:0] frame_t [8];

    logic clk;
    logic rst_n;

    tdm_deframer8_if #(.W(W)) bus ();

    tdm_deframer8 #(.W(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Edge counter plus pulse monitor sampled 1 time unit after each rising edge.
    int cyc     = 0;
    int fv_cnt  = 0;
    int se_cnt  = 0;
    int both_cnt = 0;
    int fv_cyc  = 0;
    int fv_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bus.frame_valid === 1'b1) begin
            fv_cnt++;
            fv_prev = fv_cyc;
            fv_cyc  = cyc;
        end
        if (bus.sync_err === 1'b1) se_cnt++;
        if (bus.frame_valid === 1'b1 && bus.sync_err === 1'b1) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input frame_t e);
        chk({tag, ".ch1"}, 32'(bus.ch1), 32'(e[0]));
        chk({tag, ".ch2"}, 32'(bus.ch2), 32'(e[1]));
        chk({tag, ".ch3"}, 32'(bus.ch3), 32'(e[2]));
        chk({tag, ".ch4"}, 32'(bus.ch4), 32'(e[3]));
        chk({tag, ".ch5"}, 32'(bus.ch5), 32'(e[4]));
        chk({tag, ".ch6"}, 32'(bus.ch6), 32'(e[5]));
        chk({tag, ".ch7"}, 32'(bus.ch7), 32'(e[6]));
        chk({tag, ".ch8"}, 32'(bus.ch8), 32'(e[7]));
    endtask

    // Called at a falling edge; the strobe is sampled by the next rising edge.
    task automatic strobe(input logic sd, input logic fs, input int gap);
        bus.bit_en = 1'b1;
        bus.sdata  = sd;
        bus.fsync  = fs;
        @(negedge clk);
        bus.bit_en = 1'b0;
        bus.fsync  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int nbits, input logic fs_first, input int gap);
        for (int b = 0; b < nbits; b++)
            strobe(w[W-1-b], (b == 0) ? fs_first : 1'b0, gap);
    endtask

    task automatic send_frame(input frame_t f, input logic fs, input int gap);
        for (int s = 0; s < 8; s++) send_bits(f[s], W, (s == 0) ? fs : 1'b0, gap);
    endtask

    frame_t zero_f  = '{default: 16'h0000};
    frame_t f1      = '{16'h0001, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h1234, 16'hABCD, 16'h0000, 16'h5A5A};
    frame_t fa      = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    frame_t fc3     = '{default: 16'hC3C3};
    frame_t fclean  = '{16'hDEAD, 16'hBEEF, 16'h0F0F, 16'hF0F0, 16'h0102, 16'h8001, 16'h7FFE, 16'h3C3C};
    frame_t f4      = '{16'hFFFF, 16'h0000, 16'hAAAA, 16'h5555, 16'h8000, 16'h7FFF, 16'h1357, 16'h2468};

    int t0;
    int fv0;
    int se0;

    initial begin
        bus.bit_en = 1'b0;
        bus.sdata  = 1'b0;
        bus.fsync  = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);

        chk_frame("reset", zero_f);
        chk("reset.locked", 32'(bus.locked), 32'd0);
        chk("reset.fv", 32'(bus.frame_valid), 32'd0);
        chk("reset.se", 32'(bus.sync_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: contiguous strobes; LSB of slot 7 is sampled 127 edges after the MSB of slot 0.
        t0 = cyc + 1;
        send_frame(f1, 1'b1, 0);
        chk("t1.fv_cnt", 32'(fv_cnt), 32'd1);
        chk("t1.fv_edge", 32'(fv_cyc - t0), 32'd127);
        chk_frame("t1", f1);
        chk("t1.locked", 32'(bus.locked), 32'd1);
        chk("t1.se_cnt", 32'(se_cnt), 32'd0);

        // Test 2: two back-to-back frames, one strobe every 3rd cycle.
        send_frame(fa, 1'b1, 2);
        chk("t2.fvA_cnt", 32'(fv_cnt), 32'd2);
        chk_frame("t2.A", fa);
        for (int s = 0; s < 7; s++) send_bits(fc3[s], W, (s == 0), 2);
        send_bits(fc3[7], W - 1, 1'b0, 2);
        chk("t2.hold_fv_cnt", 32'(fv_cnt), 32'd2);
        chk_frame("t2.hold", fa);
        strobe(fc3[7][0], 1'b0, 2);
        chk("t2.fvB_cnt", 32'(fv_cnt), 32'd3);
        chk("t2.fv_spacing", 32'(fv_cyc - fv_prev), 32'd384);
        chk_frame("t2.B", fc3);
        chk("t2.se_cnt", 32'(se_cnt), 32'd0);

        // Test 3: fsync arrives at bit 5 of slot 3.
        for (int s = 0; s < 3; s++) send_bits(f4[s], W, (s == 0), 0);
        send_bits(f4[3], 5, 1'b0, 0);
        t0 = cyc + 1;
        send_bits(fclean[0], 1, 1'b1, 0);
        chk("t3.se_cnt", 32'(se_cnt), 32'd1);
        chk("t3.locked", 32'(bus.locked), 32'd1);
        chk("t3.no_fv", 32'(fv_cnt), 32'd3);
        chk_frame("t3.hold", fc3);
        send_bits(fclean[0] << 1, W - 1, 1'b0, 0);
        for (int s = 1; s < 8; s++) send_bits(fclean[s], W, 1'b0, 0);
        chk("t3.fv_cnt", 32'(fv_cnt), 32'd4);
        chk("t3.fv_edge", 32'(fv_cyc - t0), 32'd127);
        chk_frame("t3.clean", fclean);
        chk("t3.se_total", 32'(se_cnt), 32'd1);

        // Test 4: next frame starts without fsync.
        send_bits(f4[0], 1, 1'b0, 0);
        chk("t4.se_cnt", 32'(se_cnt), 32'd2);
        chk("t4.unlocked", 32'(bus.locked), 32'd0);
        send_bits(f4[0] << 1, W - 1, 1'b0, 0);
        for (int s = 1; s < 8; s++) send_bits(f4[s], W, 1'b0, 0);
        chk("t4.no_fv", 32'(fv_cnt), 32'd4);
        chk("t4.no_more_se", 32'(se_cnt), 32'd2);
        chk_frame("t4.hold", fclean);
        send_frame(f4, 1'b1, 0);
        chk("t4.fv_cnt", 32'(fv_cnt), 32'd5);
        chk("t4.relocked", 32'(bus.locked), 32'd1);
        chk_frame("t4.data", f4);

        // Test 5: reset in the middle of slot 4.
        for (int s = 0; s < 4; s++) send_bits(f1[s], W, (s == 0), 0);
        send_bits(f1[4], 8, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk_frame("t5.async", zero_f);
        chk("t5.locked", 32'(bus.locked), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fv0 = fv_cnt;
        send_frame(fclean, 1'b1, 1);
        chk("t5.fv_cnt", 32'(fv_cnt - fv0), 32'd1);
        chk_frame("t5.data", fclean);
        chk("t5.se_cnt", 32'(se_cnt), 32'd2);

        // Test 6: fsync never asserted after a fresh reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fv0 = fv_cnt;
        se0 = se_cnt;
        send_frame(f1, 1'b0, 0);
        send_frame(fa, 1'b0, 0);
        chk_frame("t6", zero_f);
        chk("t6.locked", 32'(bus.locked), 32'd0);
        chk("t6.no_fv", 32'(fv_cnt - fv0), 32'd0);
        chk("t6.no_se", 32'(se_cnt - se0), 32'd0);

        chk("never_fv_and_se", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
